// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared processor definitions for the hazard controller: register index width,
// the zero register and the mult/div sequencer state encoding.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MD_WAIT = 1'b1;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags a D/X load whose destination is read by the
// instruction sitting in F/D. Writes to r0 never create a dependence.
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] fd_rs1,
  input  logic [REG_W-1:0] fd_rs2,
  input  logic             fd_uses_rs1,
  input  logic             fd_uses_rs2,
  input  logic             dx_is_load,
  input  logic [REG_W-1:0] dx_rd,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = fd_uses_rs1 && (fd_rs1 == dx_rd);
  assign rs2_hit  = fd_uses_rs2 && (fd_rs2 == dx_rd);
  assign load_use = dx_is_load && (dx_rd != ZERO_REG) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the F/D, D/X, X/M, M/W latches and the PC. Enables
// and flushes are combinational so they settle before the negedge latch capture.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
)
(
  input  logic             clk,
  input  logic             clr,
  input  logic [REG_W-1:0] fd_rs1,
  input  logic [REG_W-1:0] fd_rs2,
  input  logic             fd_uses_rs1,
  input  logic             fd_uses_rs2,
  input  logic             dx_is_load,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             dx_is_md,
  input  logic             md_ready,
  input  logic             br_taken,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_en,
  output logic             dx_flush,
  output logic             xm_en,
  output logic             xm_flush,
  output logic             mw_en,
  output logic             md_start,
  output logic             md_err,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TO_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic            load_use;

  pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
    .fd_rs1      (fd_rs1),
    .fd_rs2      (fd_rs2),
    .fd_uses_rs1 (fd_uses_rs1),
    .fd_uses_rs2 (fd_uses_rs2),
    .dx_is_load  (dx_is_load),
    .dx_rd       (dx_rd),
    .load_use    (load_use)
  );

  // Reset dominates everything; in MD_WAIT the other hazard sources are ignored
  // because the front of the pipe is frozen anyway.
  always_comb begin
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    dx_en      = 1'b1;
    xm_en      = 1'b1;
    mw_en      = 1'b1;
    fd_flush   = 1'b0;
    dx_flush   = 1'b0;
    xm_flush   = 1'b0;
    md_start   = 1'b0;
    md_err     = 1'b0;
    md_busy    = 1'b0;
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    if (clr) begin
      fd_flush = 1'b1;
      dx_flush = 1'b1;
      xm_flush = 1'b1;
    end else if (state == ST_RUN) begin
      if (dx_is_md) begin
        md_start   = 1'b1;
        pc_en      = 1'b0;
        fd_en      = 1'b0;
        dx_en      = 1'b0;
        xm_flush   = 1'b1;
        state_nxt  = ST_MD_WAIT;
        to_cnt_nxt = '0;
      end else if (br_taken) begin
        fd_flush = 1'b1;
        dx_flush = 1'b1;
      end else if (load_use) begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        dx_flush = 1'b1;
      end
    end else begin
      md_busy = 1'b1;
      if (md_ready) begin
        state_nxt = ST_RUN;
      end else if (to_cnt == TO_LAST) begin
        md_err    = 1'b1;
        state_nxt = ST_RUN;
      end else begin
        pc_en      = 1'b0;
        fd_en      = 1'b0;
        dx_en      = 1'b0;
        xm_flush   = 1'b1;
        to_cnt_nxt = to_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= ST_RUN;
      to_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      if (!pc_en) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for the hazard controller: a fixed vector table, directed mult/div
// sequences and random traffic, all checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    bit         clr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    bit         u1;
    bit         u2;
    bit         is_load;
    logic [4:0] rd;
    bit         is_md;
    bit         ready;
    bit         br;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [10:0] exp;
  } vec_t;

  // {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, md_start, md_err, md_busy}
  localparam logic [10:0] V_IDLE  = 11'b11111_000_000;
  localparam logic [10:0] V_CLR   = 11'b11111_111_000;
  localparam logic [10:0] V_LU    = 11'b00111_010_000;
  localparam logic [10:0] V_BR    = 11'b11111_110_000;
  localparam logic [10:0] V_START = 11'b00011_001_100;
  localparam logic [10:0] V_WAIT  = 11'b00011_001_001;
  localparam logic [10:0] V_REL   = 11'b11111_000_001;
  localparam logic [10:0] V_TOREL = 11'b11111_000_011;

  logic clk = 1'b0;
  logic clr;
  logic [4:0] fd_rs1, fd_rs2, dx_rd;
  logic fd_uses_rs1, fd_uses_rs2, dx_is_load, dx_is_md, md_ready, br_taken;

  logic a_pc, a_fd, a_fdf, a_dx, a_dxf, a_xm, a_xmf, a_mw, a_st, a_er, a_bz;
  logic [31:0] a_stall;
  logic b_pc, b_fd, b_fdf, b_dx, b_dxf, b_xm, b_xmf, b_mw, b_st, b_er, b_bz;
  logic [3:0] b_stall;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  int     to_lim[2]  = '{8, 40};
  longint cnt_max[2] = '{64'hFFFF_FFFF, 64'd15};
  bit     m_wait[2];
  int     m_waited[2];
  longint m_stalls[2];
  bit     m_known = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(32)) dut_a (
    .clk(clk), .clr(clr), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_uses_rs1(fd_uses_rs1), .fd_uses_rs2(fd_uses_rs2),
    .dx_is_load(dx_is_load), .dx_rd(dx_rd), .dx_is_md(dx_is_md),
    .md_ready(md_ready), .br_taken(br_taken),
    .pc_en(a_pc), .fd_en(a_fd), .fd_flush(a_fdf), .dx_en(a_dx), .dx_flush(a_dxf),
    .xm_en(a_xm), .xm_flush(a_xmf), .mw_en(a_mw), .md_start(a_st), .md_err(a_er),
    .md_busy(a_bz), .stall_cycles(a_stall)
  );

  pipeline_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(4)) dut_b (
    .clk(clk), .clr(clr), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_uses_rs1(fd_uses_rs1), .fd_uses_rs2(fd_uses_rs2),
    .dx_is_load(dx_is_load), .dx_rd(dx_rd), .dx_is_md(dx_is_md),
    .md_ready(md_ready), .br_taken(br_taken),
    .pc_en(b_pc), .fd_en(b_fd), .fd_flush(b_fdf), .dx_en(b_dx), .dx_flush(b_dxf),
    .xm_en(b_xm), .xm_flush(b_xmf), .mw_en(b_mw), .md_start(b_st), .md_err(b_er),
    .md_busy(b_bz), .stall_cycles(b_stall)
  );

  function automatic logic [10:0] out_a();
    return {a_pc, a_fd, a_dx, a_xm, a_mw, a_fdf, a_dxf, a_xmf, a_st, a_er, a_bz};
  endfunction

  function automatic logic [10:0] out_b();
    return {b_pc, b_fd, b_dx, b_xm, b_mw, b_fdf, b_dxf, b_xmf, b_st, b_er, b_bz};
  endfunction

  // Expected control word from the pipeline rules and the model's notion of
  // whether a mult/div is outstanding and how many cycles it has stalled.
  function automatic logic [10:0] model_out(int i, stim_t s);
    bit dep;
    dep = s.is_load && (s.rd != 0) &&
          ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (s.clr) return V_CLR;
    if (!m_wait[i]) begin
      if (s.is_md) return V_START;
      if (s.br)    return V_BR;
      if (dep)     return V_LU;
      return V_IDLE;
    end
    if (s.ready) return V_REL;
    if (m_waited[i] + 1 == to_lim[i]) return V_TOREL;
    return V_WAIT;
  endfunction

  task automatic model_step(int i, stim_t s, logic [10:0] v);
    if (s.clr) begin
      m_wait[i] = 0;
      m_waited[i] = 0;
      m_stalls[i] = 0;
    end else begin
      if (!v[10] && m_stalls[i] < cnt_max[i]) m_stalls[i]++;
      if (!m_wait[i]) begin
        if (s.is_md) begin
          m_wait[i] = 1;
          m_waited[i] = 0;
        end
      end else if (s.ready || (m_waited[i] + 1 == to_lim[i])) begin
        m_wait[i] = 0;
      end else begin
        m_waited[i]++;
      end
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive, let the combinational outputs settle, compare, clock the model.
  task automatic step(stim_t s, bit use_tbl, logic [10:0] tbl_exp);
    logic [10:0] va, vb;
    clr = s.clr; fd_rs1 = s.rs1; fd_rs2 = s.rs2; fd_uses_rs1 = s.u1; fd_uses_rs2 = s.u2;
    dx_is_load = s.is_load; dx_rd = s.rd; dx_is_md = s.is_md; md_ready = s.ready;
    br_taken = s.br;
    #3;
    va = model_out(0, s);
    vb = model_out(1, s);
    chk("ctrl_a", 64'(out_a()), 64'(va));
    chk("ctrl_b", 64'(out_b()), 64'(vb));
    if (use_tbl) chk("table", 64'(out_a()), 64'(tbl_exp));
    if (m_known) begin
      chk("stall_a", 64'(a_stall), 64'(m_stalls[0]));
      chk("stall_b", 64'(b_stall), 64'(m_stalls[1]));
    end
    @(posedge clk);
    model_step(0, s, va);
    model_step(1, s, vb);
    if (s.clr) m_known = 1;
    cyc++;
    #1;
  endtask

  function automatic stim_t mk(bit c, int r1, int r2, bit u1, bit u2, bit ld, int rd,
                               bit md, bit rdy, bit br);
    stim_t s;
    s.clr = c; s.rs1 = 5'(r1); s.rs2 = 5'(r2); s.u1 = u1; s.u2 = u2;
    s.is_load = ld; s.rd = 5'(rd); s.is_md = md; s.ready = rdy; s.br = br;
    return s;
  endfunction

  initial begin
    vec_t tbl[$];
    stim_t idle;
    longint s0;
    int n_err, n_low;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), V_CLR});
    tbl.push_back('{mk(1, 5, 0, 1, 0, 1, 5, 0, 0, 0), V_CLR});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), V_IDLE});
    tbl.push_back('{mk(0, 5, 0, 1, 0, 1, 5, 0, 0, 0), V_LU});
    tbl.push_back('{mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0), V_IDLE});
    tbl.push_back('{mk(0, 1, 7, 0, 1, 1, 7, 0, 0, 0), V_LU});
    tbl.push_back('{mk(0, 1, 7, 0, 0, 1, 7, 0, 0, 0), V_IDLE});
    tbl.push_back('{mk(0, 5, 0, 1, 0, 0, 5, 0, 0, 0), V_IDLE});
    tbl.push_back('{mk(0, 5, 0, 1, 0, 1, 5, 0, 0, 1), V_BR});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), V_IDLE});
    tbl.push_back('{mk(0, 4, 3, 1, 1, 1, 3, 0, 0, 0), V_LU});
    tbl.push_back('{mk(0, 4, 3, 1, 1, 1, 3, 1, 0, 1), V_START});
    tbl.push_back('{mk(0, 4, 3, 1, 1, 1, 3, 1, 0, 1), V_WAIT});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), V_REL});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), V_START});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), V_REL});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), V_IDLE});
    for (int i = 0; i < tbl.size(); i++) step(tbl[i].s, 1, tbl[i].exp);

    // Reset must zero the counter seen by the datapath.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, V_CLR);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, V_CLR);
    step(idle, 1, V_IDLE);
    chk("stall_after_clr", 64'(a_stall), 64'd0);

    // md_ready arrives six cycles after md_start.
    s0 = m_stalls[0]; n_err = 0; n_low = 0;
    for (int k = 0; k <= 6; k++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, (k == 6), 0), 0, '0);
    end
    chk("md_stalls6", 64'(a_stall), 64'(s0 + 6));
    step(idle, 1, V_IDLE);

    // Timeout: md_ready never arrives, release on the eighth cycle after start.
    s0 = m_stalls[0];
    for (int k = 0; k <= 8; k++) begin
      clr = 0; dx_is_md = 1; md_ready = 0;
      #3;
      if (a_er) n_err++;
      if (!a_pc) n_low++;
      #0;
      step(mk(0, 0, 0, 0, 0, 0, 0, (k == 0), 0, 0), 0, '0);
    end
    chk("timeout_err_pulses", 64'(n_err), 64'd1);
    chk("timeout_stalls", 64'(n_low), 64'd8);
    chk("timeout_cnt", 64'(a_stall), 64'(s0 + 8));
    step(idle, 1, V_IDLE);

    // Reset landing on the third MD_WAIT cycle abandons the operation quietly.
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, V_START);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, V_WAIT);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, V_WAIT);
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, V_CLR);
    step(idle, 1, V_IDLE);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, V_IDLE);

    // Saturation of the narrow counter in the second instance.
    for (int k = 0; k < 20; k++) step(mk(0, 6, 0, 1, 0, 1, 6, 0, 0, 0), 1, V_LU);
    chk("sat_b", 64'(b_stall), 64'd15);

    // Random traffic on a small register range so dependences are frequent.
    for (int k = 0; k < 600; k++) begin
      stim_t s;
      s = mk(($urandom_range(0, 59) == 0),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0));
      step(s, 0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline's four negedge pipeline latches (F/D, D/X, X/M, M/W) and the PC register. It drives each latch's in_en and clr from three hazard sources:
- load-use dependence
- taken branch resolved in X
- multi-cycle mult/div in X, handled by an FSM with a timeout counter

It also keeps a saturating stall-cycle counter for performance debug. It sits beside the datapath in the processor top level.

Parameters:
MD_TIMEOUT, 40, max cycles to wait for md_ready after md_start before forced release
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  pipeline clock; state and counters update on posedge
clr  in  1  synchronous active-high reset
fd_rs1  in  5  source reg 1 of instr in F/D latch
fd_rs2  in  5  source reg 2 of instr in F/D latch
fd_uses_rs1  in  1  F/D instr reads rs1
fd_uses_rs2  in  1  F/D instr reads rs2
dx_is_load  in  1  D/X instr is a load
dx_rd  in  5  dest reg of D/X instr
dx_is_md  in  1  D/X instr is mult/div
md_ready  in  1  mult/div unit result valid (level)
br_taken  in  1  branch/jump in X resolved taken
pc_en  out  1  PC write enable
fd_en  out  1  F/D latch in_en
fd_flush  out  1  F/D latch clr
dx_en  out  1  D/X latch in_en
dx_flush  out  1  D/X latch clr
xm_en  out  1  X/M latch in_en
xm_flush  out  1  X/M latch clr
mw_en  out  1  M/W latch in_en
md_start  out  1  one-cycle start pulse to mult/div unit
md_err  out  1  one-cycle pulse on timeout release
md_busy  out  1  high while FSM in MD_WAIT
stall_cycles  out  CNT_W  count of cycles with pc_en=0, saturating

Behaviour:
- Registered elements: FSM state, timeout counter (width clog2(MD_TIMEOUT)), stall_cycles. All stall/flush/enable outputs are combinational from state and current inputs, so they are valid before the latches' negedge capture.
- Reset (clr=1 at posedge):
  - state=RUN, timeout counter=0, stall_cycles=0.
  - While clr is high, outputs are forced: all *_en=1, fd_flush=dx_flush=xm_flush=1, md_start=md_err=md_busy=0.
  - clr mid-MD_WAIT abandons the operation with no md_err.
- Default in RUN with no hazard: all en=1, all flush=0, md_start=0.
- States: RUN, MD_WAIT.
- Priority in RUN: dx_is_md > br_taken > load-use. br_taken and dx_is_md both high is illegal; md wins.
- RUN, dx_is_md=1:
  - md_start=1 for this cycle only.
  - pc_en=fd_en=dx_en=0.
  - xm_en=1, xm_flush=1 (bubble into X/M).
  - mw_en=1.
  - Next state MD_WAIT, counter=0.
- MD_WAIT, md_ready=0 and counter<MD_TIMEOUT-1:
  - Same stall pattern, md_start=0, md_busy=1, counter+1.
- MD_WAIT, md_ready=1:
  - Release: all en=1, all flush=0, md_busy=1 this cycle.
  - Next state RUN; the md result enters X/M.
- MD_WAIT, md_ready=0 and counter==MD_TIMEOUT-1:
  - Release as above, md_err=1 for one cycle.
  - Next state RUN.
- md_ready while in RUN is ignored.
- Back-to-back md ops: after release the new D/X instr is re-evaluated in RUN, giving a fresh md_start the cycle after release.
- RUN, br_taken=1: fd_flush=dx_flush=1, all en=1 (PC loads target, two younger instrs squashed).
- RUN, load-use:
  - Condition: dx_is_load & dx_rd!=0 & ((fd_uses_rs1 & fd_rs1==dx_rd) | (fd_uses_rs2 & fd_rs2==dx_rd)).
  - Response: pc_en=fd_en=0, dx_flush=1, dx_en=1, xm_en=mw_en=1.
  - The condition self-clears the next cycle because D/X then holds a bubble.
- A load to r0 never stalls.
- mw_en is always 1 outside reset.
- stall_cycles increments each posedge where pc_en=0 and clr=0; holds at all-ones.

Decomposition:
- Shared processor package: FSM state encoding (RUN=0, MD_WAIT=1), REG_W=5, zero-register constant.
- One natural sub-module, hazard_detect: purely combinational load-use comparator. The FSM and counters stay in the top.

Test Plan:
- clr high 2 cycles, then low with no hazards -> during clr all flush=1 and en=1; afterwards all en=1, flush=0, stall_cycles=0.
- Load-use: dx_is_load=1, dx_rd=5, fd_rs1=5, fd_uses_rs1=1 for one cycle -> pc_en=fd_en=0, dx_flush=1, stall_cycles becomes 1. Repeat with dx_rd=0 -> no stall.
- dx_is_md=1, md_ready rises 6 cycles after md_start -> md_start one pulse; pc_en=0 for 7 cycles including the release cycle? No: pc_en=0 for 6 cycles, then the release cycle has all en=1; xm_flush=1 for 6 cycles; stall_cycles=6; md_err=0.
- MD_TIMEOUT=8, md_ready held 0 -> release after 8 stalled cycles with md_err=1 for one cycle, state RUN.
- br_taken=1 coincident with load-use match -> fd_flush=dx_flush=1, pc_en=1, no stall counted.
- clr asserted on 3rd MD_WAIT cycle -> next cycle state RUN, md_busy=0, md_err never pulses.
